// File: rtl/joy_serial_2p.sv
// Two-player serial joystick reader: clocks a chained 74HC165-style adapter and
// publishes active-high button words after two matching frames (disconnect clears at once).
module joy_serial_2p #(
  parameter int HALF_PERIOD     = 24,
  parameter int BITS_PER_PLAYER = 12,
  parameter int GAP_CYCLES      = 48000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        joy_data,
  output logic        joy_clk,
  output logic        joy_load,
  output logic [15:0] joystick1,
  output logic [15:0] joystick2,
  output logic        present,
  output logic        frame_done
);

  localparam int N    = BITS_PER_PLAYER;
  localparam int NB   = 2 * N;
  localparam int CMAX = (GAP_CYCLES > HALF_PERIOD) ? GAP_CYCLES : HALF_PERIOD;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int IW   = (NB > 1) ? $clog2(NB) : 1;

  localparam logic [CW-1:0] GAP_LD   = CW'(GAP_CYCLES);
  localparam logic [CW-1:0] HP_LD    = CW'(HALF_PERIOD);
  localparam logic [IW-1:0] IDX_LAST = IW'(NB - 1);

  typedef enum logic [2:0] {
    ST_GAP,
    ST_LOAD,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_DONE
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [IW-1:0] idx, idx_nxt;
  logic [NB-1:0] raw, prev, cur;
  logic          cnt_last;
  logic          sample;
  logic          done;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt - CW'(1);
    idx_nxt   = idx;
    sample    = 1'b0;
    done      = 1'b0;
    cnt_last  = (cnt == CW'(1));
    cur       = ~raw;

    case (state)
      ST_GAP: begin
        if (cnt_last) begin
          state_nxt = ST_LOAD;
          cnt_nxt   = HP_LD;
        end
      end
      ST_LOAD: begin
        if (cnt_last) begin
          state_nxt = ST_SHIFT_LO;
          cnt_nxt   = HP_LD;
          idx_nxt   = '0;
        end
      end
      ST_SHIFT_LO: begin
        // Data is sampled at the very end of the low phase, just before the next rising edge.
        if (cnt_last) begin
          sample = 1'b1;
          if (idx == IDX_LAST) begin
            state_nxt = ST_DONE;
            cnt_nxt   = GAP_LD;
          end else begin
            state_nxt = ST_SHIFT_HI;
            cnt_nxt   = HP_LD;
          end
        end
      end
      ST_SHIFT_HI: begin
        if (cnt_last) begin
          state_nxt = ST_SHIFT_LO;
          cnt_nxt   = HP_LD;
          idx_nxt   = idx + IW'(1);
        end
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_GAP;
        cnt_nxt   = GAP_LD;
      end
      default: begin
        state_nxt = ST_GAP;
        cnt_nxt   = GAP_LD;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_GAP;
      cnt        <= GAP_LD;
      idx        <= '0;
      raw        <= '0;
      prev       <= '1;
      joy_clk    <= 1'b0;
      joy_load   <= 1'b1;
      joystick1  <= '0;
      joystick2  <= '0;
      present    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      idx        <= idx_nxt;
      joy_clk    <= (state_nxt == ST_SHIFT_HI);
      joy_load   <= (state_nxt != ST_LOAD);
      frame_done <= done;

      if (sample) begin
        raw[idx] <= joy_data;
      end

      if (done) begin
        prev <= cur;
        // An all-low wire means nothing is driving the line: drop outputs without filtering.
        if (raw == '0) begin
          joystick1 <= '0;
          joystick2 <= '0;
          present   <= 1'b0;
        end else if (cur == prev) begin
          joystick1 <= 16'(cur[N-1:0]);
          joystick2 <= 16'(cur[NB-1:N]);
          present   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_joy_serial_2p.sv
// Randomised bench for joy_serial_2p: shift-register pad model, frame-level scoreboard, protocol timing monitor.
module tb_joy_serial_2p;

  localparam int HP  = 3;
  localparam int N   = 12;
  localparam int GAP = 40;
  localparam int NB  = 2 * N;
  localparam int PER = GAP + 4 * N * HP + 1;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        joy_data;
  logic        joy_clk, joy_load, present, frame_done;
  logic [15:0] joystick1, joystick2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  joy_serial_2p #(
    .HALF_PERIOD    (HP),
    .BITS_PER_PLAYER(N),
    .GAP_CYCLES     (GAP)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .joy_data  (joy_data),
    .joy_clk   (joy_clk),
    .joy_load  (joy_load),
    .joystick1 (joystick1),
    .joystick2 (joystick2),
    .present   (present),
    .frame_done(frame_done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Adapter model: parallel load while joy_load is low, shift one place per joy_clk rise.
  logic [NB-1:0] pad_wire  = '1;
  logic [NB-1:0] shreg     = '1;
  logic          pad_clk_q = 1'b0;
  logic          rand_mode = 1'b1;
  logic          jd_rand   = 1'b0;

  assign joy_data = rand_mode ? jd_rand : shreg[0];

  always @(negedge clk) begin
    if (!joy_load) shreg = pad_wire;
    else if (joy_clk && !pad_clk_q) shreg = shreg >> 1;
    pad_clk_q = joy_clk;
  end

  // Frame-level reference model and scoreboard.
  typedef struct packed {
    logic [15:0] j1;
    logic [15:0] j2;
    logic        pr;
  } exp_t;

  exp_t          sb_q[$];
  exp_t          mon_e;
  logic [NB-1:0] m_prev;
  logic [15:0]   m_j1, m_j2;
  logic          m_pr;

  task automatic model_reset();
    m_prev = '1;
    m_j1   = '0;
    m_j2   = '0;
    m_pr   = 1'b0;
  endtask

  task automatic model_push(input logic [NB-1:0] w);
    logic [NB-1:0] c;
    exp_t e;
    c = ~w;
    if (w == '0) begin
      m_j1 = '0;
      m_j2 = '0;
      m_pr = 1'b0;
    end else if (c == m_prev) begin
      m_j1 = {4'h0, c[11:0]};
      m_j2 = {4'h0, c[23:12]};
      m_pr = 1'b1;
    end
    m_prev = c;
    e.j1 = m_j1;
    e.j2 = m_j2;
    e.pr = m_pr;
    sb_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (reset_n && frame_done) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_underflow: frame_done with no expected frame queued");
      end else begin
        mon_e = sb_q.pop_front();
        chk("joystick1", {16'h0, joystick1}, {16'h0, mon_e.j1});
        chk("joystick2", {16'h0, joystick2}, {16'h0, mon_e.j2});
        chk("present", {31'h0, present}, {31'h0, mon_e.pr});
      end
    end
  end

  // Protocol timing monitor.
  int   cyc = 0, last_fd = -1, load_len = 0, lo_cnt = 0, hi_cnt = 0, rises = 0;
  logic shifting = 1'b0, q_clk = 1'b0, q_load = 1'b1, q_fd = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (!reset_n) begin
      last_fd = -1; load_len = 0; lo_cnt = 0; hi_cnt = 0; rises = 0;
      shifting = 1'b0; q_clk = 1'b0; q_load = 1'b1; q_fd = 1'b0;
    end else begin
      if (!joy_load) load_len++;
      if (joy_load && !q_load) begin
        chk("load_len", load_len, HP);
        load_len = 0;
        shifting = 1'b1;
      end
      if (joy_clk && !q_clk) begin
        rises++;
        chk("low_phase", lo_cnt, HP);
        lo_cnt = 0;
      end
      if (!joy_clk && q_clk) begin
        chk("high_phase", hi_cnt, HP);
        hi_cnt = 0;
      end
      if (frame_done) begin
        chk("last_low_phase", lo_cnt, HP + 1);
        chk("rises_per_frame", rises, 2 * N - 1);
        chk("fd_width", {31'h0, q_fd}, 32'h0);
        if (last_fd >= 0) chk("frame_period", cyc - last_fd, PER);
        last_fd = cyc; rises = 0; lo_cnt = 0; shifting = 1'b0;
      end
      if (shifting && !joy_clk) lo_cnt++;
      if (joy_clk) hi_cnt++;
      q_clk = joy_clk; q_load = joy_load; q_fd = frame_done;
    end
  end

  function automatic logic [NB-1:0] pads(input logic [11:0] p1, input logic [11:0] p2);
    return ~{p2, p1};
  endfunction

  task automatic wait_fd();
    bit seen = 0;
    for (int i = 0; i < 3 * PER; i++) begin
      @(negedge clk);
      if (frame_done) begin
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL fd_timeout: no frame_done within %0d cycles", 3 * PER);
    end
  endtask

  task automatic next_frame(input logic [NB-1:0] w);
    wait_fd();
    pad_wire = w;
    model_push(w);
  endtask

  initial begin
    logic [NB-1:0] seq[$];
    logic [NB-1:0] w, x;
    logic          q;
    int            n, r;

    model_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      jd_rand = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("rst_joy_clk", {31'h0, joy_clk}, 32'h0);
      chk("rst_joy_load", {31'h0, joy_load}, 32'h1);
      chk("rst_joystick1", {16'h0, joystick1}, 32'h0);
      chk("rst_joystick2", {16'h0, joystick2}, 32'h0);
      chk("rst_present", {31'h0, present}, 32'h0);
      chk("rst_frame_done", {31'h0, frame_done}, 32'h0);
    end
    rand_mode = 1'b0;
    pad_wire  = '1;
    model_push(pad_wire);
    reset_n = 1'b1;

    seq.push_back(24'hFFFFF0);
    seq.push_back(24'hFFFFF0);
    seq.push_back(pads(12'h00F, 12'h010));
    seq.push_back(pads(12'h00F, 12'h010));
    seq.push_back(pads(12'h00F, 12'h050));
    seq.push_back(pads(12'h00F, 12'h010));
    seq.push_back(pads(12'h00F, 12'h050));
    seq.push_back(pads(12'h00F, 12'h050));
    seq.push_back(24'h000000);
    seq.push_back(24'hFFFFFF);
    foreach (seq[i]) next_frame(seq[i]);

    w = 24'hFFFFFF;
    for (int i = 0; i < 20; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0) w = '0;
      else if (r < 5) w = NB'($urandom);
      next_frame(w);
    end

    x = pads(12'h0A5, 12'h123);
    next_frame(x);
    next_frame(x);
    next_frame(x);
    chk("pre_rst_present", {31'h0, present}, 32'h1);

    // Abort the current frame while bit index 10 is being shifted.
    n = 0;
    q = joy_clk;
    for (int i = 0; i < PER && n < 10; i++) begin
      @(negedge clk);
      if (joy_clk && !q) n++;
      q = joy_clk;
    end
    chk("rises_before_abort", n, 10);
    repeat (HP) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("abort_joy_clk", {31'h0, joy_clk}, 32'h0);
    chk("abort_joy_load", {31'h0, joy_load}, 32'h1);
    chk("abort_joystick1", {16'h0, joystick1}, 32'h0);
    chk("abort_joystick2", {16'h0, joystick2}, 32'h0);
    chk("abort_present", {31'h0, present}, 32'h0);
    chk("abort_frame_done", {31'h0, frame_done}, 32'h0);
    sb_q.delete();
    model_reset();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    model_push(x);

    n = 0;
    for (int i = 0; i < GAP + 10; i++) begin
      @(negedge clk);
      n++;
      if (!joy_load) break;
    end
    chk("gap_after_reset", n, GAP);

    next_frame(x);
    next_frame(x);
    wait_fd();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
